// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 LCD driver: FSM states, status layout, FIFO entry.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_EXEC
  } lcd_state_e;

  localparam int STAT_OVF_BIT  = 31;
  localparam int STAT_BUSY_BIT = 30;
  localparam int STAT_CNT_LSB  = 0;
  localparam int STAT_CNT_W    = 3;

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;

  typedef struct packed {
    logic       on;
    logic       rs;
    logic [7:0] dat;
  } lcd_entry_t;

  // One timer serves every state, so it is sized for the longest phase.
  function automatic int timer_width(input int a, input int b, input int c,
                                     input int d, input int e);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/lcd_if.sv
// Push/pop bundle between the LCD driver FSM and its command FIFO.
interface lcd_if
  import lcd_pkg::*;
#(
  parameter int DEPTH = 4
) ();

  localparam int CNTW = $clog2(DEPTH + 1);

  logic            push;
  logic            pop;
  lcd_entry_t      wdat;
  lcd_entry_t      rdat;
  logic            full;
  logic            empty;
  logic [CNTW-1:0] count;

  modport master (output push, pop, wdat, input rdat, full, empty, count);
  modport slave  (input push, pop, wdat, output rdat, full, empty, count);

endinterface

// File: rtl/lcd_fifo.sv
// First-word-fall-through FIFO of LCD entries; pushes when full and pops when empty are ignored.
module lcd_fifo
  import lcd_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  i_clk,
  input  logic  i_rst_n,
  lcd_if.slave  bus
);

  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);

  typedef logic [AW-1:0] ptr_t;

  lcd_entry_t      r_mem [DEPTH];
  ptr_t            r_rd_ptr;
  ptr_t            r_wr_ptr;
  logic [CNTW-1:0] r_count;
  logic            w_push;
  logic            w_pop;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  assign w_push    = bus.push && !bus.full;
  assign w_pop     = bus.pop && !bus.empty;
  assign bus.full  = (r_count == CNTW'(DEPTH));
  assign bus.empty = (r_count == '0);
  assign bus.count = r_count;
  assign bus.rdat  = r_mem[r_rd_ptr];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNTW'(1);
        2'b01:   r_count <= r_count - CNTW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.wdat;
  end

endmodule

// File: rtl/lcd_driver.sv
// HD44780 write-only driver: queues LSU writes, replays each as SETUP/EN pulse/HOLD then waits EXEC.
// Writes are never back-pressured; a write into a full queue is dropped and flagged in sticky ovf.
module lcd_driver
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC  = 2,
  parameter int EN_CYC     = 12,
  parameter int HOLD_CYC   = 1,
  parameter int EXEC_CYC   = 2000,
  parameter int CLR_CYC    = 80000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_lcd_wr,
  input  logic [31:0] i_lcd_wdata,
  output logic [31:0] o_lcd_status,
  output logic [7:0]  o_lcd_data,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic        o_lcd_en,
  output logic        o_lcd_on
);

  localparam int CNT_W = timer_width(SETUP_CYC, EN_CYC, HOLD_CYC, EXEC_CYC, CLR_CYC);

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t LD_SETUP = cnt_t'(SETUP_CYC - 1);
  localparam cnt_t LD_EN    = cnt_t'(EN_CYC - 1);
  localparam cnt_t LD_HOLD  = cnt_t'(HOLD_CYC - 1);
  localparam cnt_t LD_EXEC  = cnt_t'(EXEC_CYC - 1);
  localparam cnt_t LD_CLR   = cnt_t'(CLR_CYC - 1);

  lcd_state_e r_state;
  lcd_state_e w_state_nxt;
  cnt_t       r_cnt;
  cnt_t       w_cnt_nxt;
  logic       w_pop;
  logic       w_long_exec;
  logic       w_busy;
  logic       w_unused_wdata;
  logic       r_ovf;
  logic       r_en;
  logic       r_rs;
  logic       r_on;
  logic [7:0] r_data;

  lcd_if #(.DEPTH(FIFO_DEPTH)) fifo_bus ();

  lcd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (fifo_bus.slave)
  );

  assign fifo_bus.push  = i_lcd_wr;
  assign fifo_bus.wdat  = {i_lcd_wdata[31], i_lcd_wdata[8], i_lcd_wdata[7:0]};
  assign fifo_bus.pop   = w_pop;
  assign w_unused_wdata = ^i_lcd_wdata[30:9];

  // Clear-display and return-home are the slow HD44780 instructions.
  assign w_long_exec = !r_rs && ((r_data == CMD_CLEAR) || (r_data == CMD_HOME));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!fifo_bus.empty) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_SETUP;
          w_cnt_nxt   = LD_SETUP;
        end
      end
      ST_SETUP: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_PULSE;
          w_cnt_nxt   = LD_EN;
        end else begin
          w_cnt_nxt = r_cnt - cnt_t'(1);
        end
      end
      ST_PULSE: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_HOLD;
          w_cnt_nxt   = LD_HOLD;
        end else begin
          w_cnt_nxt = r_cnt - cnt_t'(1);
        end
      end
      ST_HOLD: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_EXEC;
          w_cnt_nxt   = w_long_exec ? LD_CLR : LD_EXEC;
        end else begin
          w_cnt_nxt = r_cnt - cnt_t'(1);
        end
      end
      ST_EXEC: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - cnt_t'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_en    <= 1'b0;
      r_data  <= '0;
      r_rs    <= 1'b0;
      r_on    <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_en    <= (w_state_nxt == ST_PULSE);
      if (w_pop) begin
        r_data <= fifo_bus.rdat.dat;
        r_rs   <= fifo_bus.rdat.rs;
        r_on   <= fifo_bus.rdat.on;
      end
      if (i_lcd_wr && fifo_bus.full) r_ovf <= 1'b1;
    end
  end

  assign w_busy = (r_state != ST_IDLE) || (fifo_bus.count != '0);

  always_comb begin
    o_lcd_status = '0;
    o_lcd_status[STAT_OVF_BIT]  = r_ovf;
    o_lcd_status[STAT_BUSY_BIT] = w_busy;
    o_lcd_status[STAT_CNT_LSB +: STAT_CNT_W] = STAT_CNT_W'(fifo_bus.count);
  end

  assign o_lcd_data = r_data;
  assign o_lcd_rs   = r_rs;
  assign o_lcd_rw   = 1'b0;
  assign o_lcd_en   = r_en;
  assign o_lcd_on   = r_on;

endmodule

// File: doc/lcd_driver.md
LCD_DRIVER -- requirements
Module: lcd_driver

Interface
REQ-001 SHALL have parameters: SETUP_CYC default 2 (RS/data setup before EN, cycles); EN_CYC default 12 (EN high width); HOLD_CYC default 1 (data hold after EN fall); EXEC_CYC default 2000 (normal command/data execute wait); CLR_CYC default 80000 (clear/home execute wait); FIFO_DEPTH default 4 (power of two).
REQ-002 SHALL have ports: i_clk in 1 system clock; i_rst_n in 1 synchronous active-low reset.
REQ-003 i_lcd_wr in 1: single-cycle write strobe from the LSU LCD output register.
REQ-004 i_lcd_wdata in 32: [7:0] byte, [8] RS, [31] display power; other bits ignored.
REQ-005 o_lcd_status out 32: {ovf, busy, 27'b0, count[2:0]} for LSU read-back.
REQ-006 o_lcd_data out 8, o_lcd_rs out 1, o_lcd_rw out 1, o_lcd_en out 1, o_lcd_on out 1: HD44780 pins, all registered.

Function
REQ-007 SHALL push {wdata[31], wdata[8], wdata[7:0]} into the FIFO on any cycle i_lcd_wr=1 and FIFO not full.
REQ-008 On i_lcd_wr=1 with FIFO full, SHALL drop the word and set sticky ovf; ovf clears only on reset.
REQ-009 count SHALL equal FIFO occupancy (0..FIFO_DEPTH); simultaneous push and pop leaves count unchanged.
REQ-010 FSM states SHALL be IDLE, SETUP, PULSE, HOLD, EXEC.
REQ-011 IDLE with FIFO non-empty: pop one entry; on the same edge, load o_lcd_data, o_lcd_rs, o_lcd_on and enter SETUP.
REQ-012 SETUP SHALL last SETUP_CYC cycles with o_lcd_en=0, then enter PULSE.
REQ-013 PULSE SHALL last EN_CYC cycles with o_lcd_en=1, then enter HOLD.
REQ-014 HOLD SHALL last HOLD_CYC cycles with o_lcd_en=0 and data/RS unchanged, then enter EXEC.
REQ-015 EXEC SHALL last CLR_CYC cycles if the entry had RS=0 and byte 0x01 or 0x02, otherwise EXEC_CYC cycles, then return to IDLE.
REQ-016 A single down-counter, width clog2(max(all _CYC)) (17 bits at defaults), SHALL time every state; each state lasts exactly its parameter value in cycles (values >= 1).
REQ-017 busy SHALL be 1 whenever state != IDLE or count != 0.
REQ-018 o_lcd_rw SHALL be constant 0 (write-only bus).
REQ-019 o_lcd_data/o_lcd_rs SHALL change only on the IDLE->SETUP edge; back-to-back entries restart at SETUP only after passing through IDLE (one IDLE cycle minimum).
REQ-020 Writes arriving during any non-IDLE state SHALL be queued per REQ-007 and never disturb the transfer in progress.

Reset
REQ-021 With i_rst_n=0 at a rising edge: state=IDLE, counter=0, FIFO emptied, ovf=0, o_lcd_data=0, o_lcd_rs=0, o_lcd_rw=0, o_lcd_en=0, o_lcd_on=0.
REQ-022 Reset mid-transfer SHALL abort immediately: o_lcd_en=0 on the next edge, queued entries discarded.

Structure
REQ-023 State enum and the status-bit positions (ovf=31, busy=30, count=[2:0]) SHALL be in shared package lcd_pkg.
REQ-024 The FIFO SHALL be a separate sub-module lcd_fifo (9+1-bit wide, FIFO_DEPTH deep, push/pop/full/empty/count); FSM and timer live in lcd_driver.

Verification (SETUP=2, EN=4, HOLD=1, EXEC=8, CLR=20)
REQ-025 Write 0x8000_0141 from idle -> next edge data=0x41, rs=1, on=1; en high exactly cycles 3-6 after load; busy=0 after 15 cycles total.
REQ-026 Write 0x0000_0001 -> rs=0, data=0x01; EXEC lasts 20 cycles; total busy 27 cycles + 1 push cycle.
REQ-027 Five writes on consecutive cycles while idle -> four accepted (one popped immediately frees a slot, so fifth accepted, ovf=0); six consecutive writes -> ovf=1 and exactly five bytes appear on the bus in order.
REQ-028 Write during PULSE -> current EN pulse width stays 4 cycles, queued byte emitted after EXEC plus one IDLE cycle.
REQ-029 Assert i_rst_n=0 during PULSE -> next edge en=0, count=0, busy=0, ovf=0, all outputs 0.
REQ-030 Simultaneous push and pop with count=2 -> count stays 2; status reads 0x4000_0002.
